// File: rtl/uart_tx_framer.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_framer
// UART transmitter with configurable width, parity and stop bits; a one-entry
// holding register lets frames go out back-to-back.
// Rev    : 1.0
// ============================================================================
module uart_tx_framer #(
    parameter int CLKS_PER_BIT = 13021,
    parameter int DATA_WIDTH   = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  tx_line,
    output logic                  tx_active,
    output logic                  tx_done
);
    localparam int c_CW = $clog2(CLKS_PER_BIT);
    localparam int c_IW = $clog2(DATA_WIDTH);
    localparam logic [c_CW-1:0] c_CNT_LAST  = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_IW-1:0] c_DATA_LAST = c_IW'(DATA_WIDTH - 1);
    localparam logic [c_IW-1:0] c_STOP_LAST = c_IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    logic [c_CW-1:0]       r_cnt;
    logic [c_IW-1:0]       r_idx;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_hold_valid;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par;
    logic                  r_tx_line;
    logic                  r_tx_active;
    logic                  r_tx_done;

    logic w_tc;
    logic w_load;

    assign w_tc   = (r_cnt == c_CNT_LAST);
    // Load from idle, or seamlessly on the last stop-bit terminal count.
    assign w_load = r_hold_valid &&
                    ((r_state == S_IDLE) ||
                     ((r_state == S_STOP) && w_tc && (r_idx == c_STOP_LAST)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_shift      <= '0;
            r_par        <= 1'b0;
            r_tx_line    <= 1'b1;
            r_tx_active  <= 1'b0;
            r_tx_done    <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;

            if (s_valid && !r_hold_valid) begin
                r_hold       <= s_data;
                r_hold_valid <= 1'b1;
            end

            if (w_load) begin
                r_hold_valid <= 1'b0;
                r_shift      <= r_hold;
                r_par        <= (PARITY == 2) ? ~^r_hold : ^r_hold;
            end

            if (r_state != S_IDLE) begin
                r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_tx_line   <= 1'b1;
                    r_tx_active <= 1'b0;
                    r_cnt       <= '0;
                    r_idx       <= '0;
                    if (w_load) begin
                        r_state     <= S_START;
                        r_tx_line   <= 1'b0;
                        r_tx_active <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_tc) begin
                        r_state   <= S_DATA;
                        r_idx     <= '0;
                        r_tx_line <= r_shift[0];
                    end
                end
                S_DATA: begin
                    if (w_tc) begin
                        if (r_idx == c_DATA_LAST) begin
                            r_idx <= '0;
                            if (PARITY != 0) begin
                                r_state   <= S_PARITY;
                                r_tx_line <= r_par;
                            end else begin
                                r_state   <= S_STOP;
                                r_tx_line <= 1'b1;
                            end
                        end else begin
                            r_idx     <= r_idx + 1'b1;
                            r_shift   <= r_shift >> 1;
                            r_tx_line <= r_shift[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (w_tc) begin
                        r_state   <= S_STOP;
                        r_tx_line <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_tc) begin
                        if (r_idx == c_STOP_LAST) begin
                            r_idx     <= '0;
                            r_tx_done <= 1'b1;
                            if (w_load) begin
                                r_state   <= S_START;
                                r_tx_line <= 1'b0;
                            end else begin
                                r_state     <= S_IDLE;
                                r_tx_line   <= 1'b1;
                                r_tx_active <= 1'b0;
                            end
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_tx_line   <= 1'b1;
                    r_tx_active <= 1'b0;
                    r_cnt       <= '0;
                    r_idx       <= '0;
                end
            endcase
        end
    end

    assign s_ready   = !r_hold_valid;
    assign tx_line   = r_tx_line;
    assign tx_active = r_tx_active;
    assign tx_done   = r_tx_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_framer.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_tx_framer
// Self-checking bench for uart_tx_framer in 8N1, 7O2 and 8E1 configurations.
// Rev    : 1.0
// ============================================================================
module tb_uart_tx_framer;
    localparam int N = 3;
    localparam int CPB_A [N] = '{4, 3, 4};
    localparam int DW_A  [N] = '{8, 7, 8};
    localparam int PAR_A [N] = '{0, 2, 1};
    localparam int STP_A [N] = '{1, 2, 1};

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] vld, rdy, line, act, done;
    logic [7:0]   d0, d2;
    logic [6:0]   d1;

    always #5 clk = ~clk;

    uart_tx_framer #(.CLKS_PER_BIT(CPB_A[0]), .DATA_WIDTH(DW_A[0]),
                     .PARITY(PAR_A[0]), .STOP_BITS(STP_A[0])) u_8n1 (
        .clk(clk), .rst(rst), .s_valid(vld[0]), .s_ready(rdy[0]), .s_data(d0),
        .tx_line(line[0]), .tx_active(act[0]), .tx_done(done[0]));

    uart_tx_framer #(.CLKS_PER_BIT(CPB_A[1]), .DATA_WIDTH(DW_A[1]),
                     .PARITY(PAR_A[1]), .STOP_BITS(STP_A[1])) u_7o2 (
        .clk(clk), .rst(rst), .s_valid(vld[1]), .s_ready(rdy[1]), .s_data(d1),
        .tx_line(line[1]), .tx_active(act[1]), .tx_done(done[1]));

    uart_tx_framer #(.CLKS_PER_BIT(CPB_A[2]), .DATA_WIDTH(DW_A[2]),
                     .PARITY(PAR_A[2]), .STOP_BITS(STP_A[2])) u_8e1 (
        .clk(clk), .rst(rst), .s_valid(vld[2]), .s_ready(rdy[2]), .s_data(d2),
        .tx_line(line[2]), .tx_active(act[2]), .tx_done(done[2]));

    // Reference model: per-cycle expected line entries {first, last, line}.
    logic [2:0] mq [N][$];
    logic       m_hold      [N];
    logic       m_done_next [N];
    logic [3:0] m_exp       [N];
    int         m_acc       [N];
    int         total = 0;
    int         bad   = 0;

    typedef struct {
        int         inst;
        logic [8:0] data;
        string      pat;
    } vec_t;
    vec_t tbl [7];

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic set_data(int i, logic [8:0] v);
        case (i)
            0:       d0 = v[7:0];
            1:       d1 = v[6:0];
            default: d2 = v[7:0];
        endcase
    endtask

    function automatic logic [8:0] cur_data(int i);
        case (i)
            0:       return {1'b0, d0};
            1:       return {2'b00, d1};
            default: return {1'b0, d2};
        endcase
    endfunction

    task automatic push_frame(int i, logic [8:0] w);
        logic bits[$];
        int   ones;
        int   n;
        logic pb;
        ones = 0;
        bits.push_back(1'b0);
        for (int b = 0; b < DW_A[i]; b++) begin
            bits.push_back(w[b]);
            if (w[b]) ones++;
        end
        if (PAR_A[i] != 0) begin
            pb = ((ones % 2) == 1);
            if (PAR_A[i] == 2) pb = !pb;
            bits.push_back(pb);
        end
        for (int s = 0; s < STP_A[i]; s++) bits.push_back(1'b1);
        n = bits.size();
        for (int k = 0; k < n; k++)
            for (int c = 0; c < CPB_A[i]; c++)
                mq[i].push_back({(k == 0 && c == 0), (k == n - 1 && c == CPB_A[i] - 1), bits[k]});
    endtask

    task automatic model_step(int i);
        logic [2:0] e;
        logic       ln, ac, dn, acc;
        if (rst) begin
            mq[i].delete();
            m_hold[i]      = 1'b0;
            m_done_next[i] = 1'b0;
            m_exp[i]       = 4'b1001;
            return;
        end
        acc            = vld[i] && !m_hold[i];
        dn             = m_done_next[i];
        m_done_next[i] = 1'b0;
        if (mq[i].size() > 0) begin
            e  = mq[i].pop_front();
            ln = e[0];
            ac = 1'b1;
            if (e[2]) m_hold[i] = 1'b0;
            if (e[1]) m_done_next[i] = 1'b1;
        end else begin
            ln = 1'b1;
            ac = 1'b0;
        end
        if (acc) begin
            push_frame(i, cur_data(i));
            m_hold[i] = 1'b1;
            m_acc[i]++;
        end
        m_exp[i] = {ln, ac, dn, !m_hold[i]};
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < N; i++) model_step(i);
        #1;
        for (int i = 0; i < N; i++)
            check($sformatf("cycle_u%0d{line,active,done,ready}", i),
                  {28'd0, line[i], act[i], done[i], rdy[i]}, {28'd0, m_exp[i]});
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < N; i++)
            if (mq[i].size() != 0 || m_hold[i] || m_done_next[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (!all_idle() && n < 400) begin
            tick();
            n++;
        end
        if (!all_idle()) begin
            total++;
            bad++;
            $display("FAIL wait_idle: got busy after %0d cycles, expected idle", n);
        end
        tick();
        check("idle_line", {29'd0, line}, 32'd7);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, act_low, dn_cnt, wait_cnt, low_cnt;

        tbl[0] = '{0, 9'h0A5, "0101001011"};
        tbl[1] = '{0, 9'h000, "0000000001"};
        tbl[2] = '{0, 9'h0FF, "0111111111"};
        tbl[3] = '{1, 9'h041, "01000001111"};
        tbl[4] = '{1, 9'h07F, "01111111011"};
        tbl[5] = '{2, 9'h007, "01110000011"};
        tbl[6] = '{2, 9'h000, "00000000001"};

        for (int i = 0; i < N; i++) begin
            m_hold[i] = 1'b0; m_done_next[i] = 1'b0; m_acc[i] = 0; m_exp[i] = 4'b1001;
        end

        // Reset held 3 cycles with valid asserted
        rst = 1'b1;
        vld = '1;
        for (int i = 0; i < N; i++) set_data(i, 9'h1A5);
        repeat (3) begin
            tick();
            for (int i = 0; i < N; i++)
                check($sformatf("rst_outputs_u%0d", i), {28'd0, line[i], act[i], done[i], rdy[i]}, 32'h9);
        end
        rst = 1'b0;
        vld = '0;
        repeat (6) tick();
        check("no_frame_after_rst_line", {29'd0, line}, 32'd7);
        check("no_frame_after_rst_active", {29'd0, act}, 32'd0);

        // Table-driven single frames
        for (int r = 0; r < 7; r++) begin
            int ti, cpb, len;
            ti  = tbl[r].inst;
            cpb = CPB_A[ti];
            len = tbl[r].pat.len();
            wait_idle();
            vld[ti] = 1'b1;
            set_data(ti, tbl[r].data);
            tick();
            check("tbl_ready_low", {31'd0, rdy[ti]}, 32'd0);
            vld[ti] = 1'b0;
            for (int k = 0; k < len * cpb; k++) begin
                tick();
                check($sformatf("tbl%0d_bit%0d", r, k / cpb), {31'd0, line[ti]},
                      {31'd0, (tbl[r].pat[k / cpb] == "1")});
                check($sformatf("tbl%0d_active", r), {31'd0, act[ti]}, 32'd1);
            end
            tick();
            check($sformatf("tbl%0d_done", r), {29'd0, line[ti], act[ti], done[ti]}, 32'b101);
        end

        // Back-to-back: 0x55, 0xAA, then a third word that must wait
        wait_idle();
        a0 = m_acc[0];
        vld[0] = 1'b1;
        set_data(0, 9'h055);
        tick();
        set_data(0, 9'h0AA);
        act_low = 0; dn_cnt = 0; wait_cnt = 0;
        for (int c = 1; c <= 81; c++) begin
            tick();
            if (c == 1) check("b2b_ready_after_load", {31'd0, rdy[0]}, 32'd1);
            if (c == 2) check("b2b_second_accepted", {31'd0, rdy[0]}, 32'd0);
            if (c == 41) check("b2b_second_start_no_gap", {30'd0, line[0], act[0]}, 32'b01);
            if (c <= 80 && !act[0]) act_low++;
            if (done[0]) dn_cnt++;
            if (m_acc[0] == a0 + 2 && !rdy[0]) wait_cnt++;
            if (m_acc[0] == a0 + 2) set_data(0, 9'h033);
            if (m_acc[0] >= a0 + 3) begin
                vld[0] = 1'b0;
                set_data(0, 9'($urandom));
            end
        end
        check("b2b_active_low_cycles", act_low, 0);
        check("b2b_done_pulses", dn_cnt, 2);
        check("b2b_third_wait_cycles", wait_cnt, 39);
        vld[0] = 1'b0;

        // Reset during data bit 3 with a word pending
        wait_idle();
        vld[0] = 1'b1;
        set_data(0, 9'h03C);
        tick();
        set_data(0, 9'h0C3);
        tick();
        tick();
        vld[0] = 1'b0;
        check("midrst_word_pending", {31'd0, rdy[0]}, 32'd0);
        repeat (15) tick();
        rst = 1'b1;
        tick();
        check("midrst_outputs", {28'd0, line[0], act[0], done[0], rdy[0]}, 32'h9);
        rst = 1'b0;
        dn_cnt = 0; low_cnt = 0;
        repeat (60) begin
            tick();
            if (done[0]) dn_cnt++;
            if (!line[0]) low_cnt++;
        end
        check("midrst_no_done", dn_cnt, 0);
        check("midrst_held_discarded", low_cnt, 0);
        vld[0] = 1'b1;
        set_data(0, 9'h096);
        tick();
        vld[0] = 1'b0;
        dn_cnt = 0;
        repeat (41) begin
            tick();
            if (done[0]) dn_cnt++;
        end
        check("post_rst_frame_done", dn_cnt, 1);

        // Randomised traffic on all three configurations
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                vld[i] = ($urandom_range(0, 2) != 0);
                set_data(i, 9'($urandom));
            end
            rst = ($urandom_range(0, 599) == 0);
            tick();
        end
        rst = 1'b0;
        vld = '0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_framer.md
# uart_tx_framer

Parametrised UART transmitter, the next generation of the fixed 8N1 transmitter. It serialises words of configurable width with an optional even or odd parity bit and one or two stop bits. The bit period is set by a parameter. A one-entry holding register behind a valid/ready input lets frames go out back-to-back with no idle gap. The block sits between the system-side producer (FIFO or control FSM) and the board TX pin, in the 125 MHz `clk` domain.

## Interface
- `CLKS_PER_BIT`, 13021, clock cycles per serial bit (125 MHz / 9600 baud); legal range ≥ 2.
- `DATA_WIDTH`, 8, data bits per frame; legal range 5..9.
- `PARITY`, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1, number of stop bits; legal values 1 or 2.

Ports:
- `clk`  in  1  system clock; the block has one clock.
- `rst`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  producer has a word on `s_data`.
- `s_ready`  out  1  holding register is empty; a word is accepted on a clock edge where `s_valid && s_ready`.
- `s_data`  in  DATA_WIDTH  word to send; it is sent LSB first.
- `tx_line`  out  1  serial output; registered; high when idle.
- `tx_active`  out  1  high for every cycle the frame is on the line.
- `tx_done`  out  1  one-cycle pulse at the end of each frame.

## Operation
- The FSM has the states IDLE, START, DATA, PARITY, STOP.
  - The PARITY state is skipped when `PARITY == 0`.
  - STOP lasts `STOP_BITS` bit periods.
- The bit-period counter is `$clog2(CLKS_PER_BIT)` bits wide. It counts 0..CLKS_PER_BIT-1, and the state or bit index advances on terminal count.
- The data bit index runs 0..DATA_WIDTH-1. The stop bit index runs 0..STOP_BITS-1.
- Holding register:
  - A handshake writes `s_data` into the holding register and sets `hold_valid`.
  - `s_ready = !hold_valid`, so it is a pure register decode with no combinational path from `s_valid`.
- Shifter load:
  - The shifter loads from the holding register, and clears `hold_valid`, on either of two edges:
    - an edge where the FSM is in IDLE;
    - the terminal-count edge of the last stop bit.
  - On that same edge the FSM enters START.
- Parity bit:
  - Even mode sends `^data`.
  - Odd mode sends `~^data`.
  - Parity is computed from the loaded shifter word.
- Frame length is (1 + DATA_WIDTH + (PARITY != 0) + STOP_BITS) × CLKS_PER_BIT cycles.
- Back-to-back frames:
  - If `hold_valid` is set at the terminal count of the last stop bit, the next start bit begins on the very next cycle.
  - There are 0 idle cycles between frames, and `tx_active` stays high across the frame boundary.
- If the holding register is empty at the end of a frame, the FSM goes to IDLE, `tx_line` goes high, and `tx_active` goes low.
- An illegal state encoding recovers to IDLE with `tx_line` = 1.

## Timing
- Reset values, and the values held while `rst` is high:
  - `tx_line` = 1, `tx_active` = 0, `tx_done` = 0;
  - `s_ready` = 1 (holding register empty);
  - FSM in IDLE, all counters 0.
- Handshakes presented while `rst` is high are ignored.
- Reset mid-frame: on the first edge with `rst` high, the frame is aborted. The held word is discarded, `tx_line` goes to 1, and no `tx_done` pulse is produced.
- Latency from idle:
  - Handshake on edge E sets `hold_valid`.
  - Edge E+1 loads the shifter; `tx_line` goes 0 and `tx_active` goes 1 from E+1.
  - `s_ready` is low only for the cycle between E and E+1.
- While a frame is running:
  - `s_ready` is high until one word is accepted, then low until that word moves to the shifter.
  - At most one word is ever pending.
- Every bit, including start, parity and each stop bit, occupies exactly CLKS_PER_BIT cycles of `tx_line`.
- `tx_done` is high for exactly 1 cycle: the first cycle after the final stop-bit cycle.
  - With back-to-back frames, that cycle coincides with the first cycle of the next start bit.
- `tx_active` is high for every cycle from the first start-bit cycle through the last stop-bit cycle.
- `s_data` is sampled only on the handshake edge; later changes on `s_data` do not affect a word already accepted.

## Test plan
- Reset behaviour (`CLKS_PER_BIT`=4, defaults otherwise): hold `rst` 3 cycles while driving `s_valid`=1.
  - Required: `tx_line`=1, `tx_active`=0, `tx_done`=0, `s_ready`=1 throughout.
  - Required: no frame starts after `rst` drops, because `s_valid` was dropped with `rst`.
- 8N1 frame (`CLKS_PER_BIT`=4): send 0xA5.
  - Required: line reads 0, then 1,0,1,0,0,1,0,1, then 1, each bit 4 cycles, 40 cycles total.
  - Required: `tx_done` pulses 1 cycle after the last stop cycle; the line goes low 1 cycle after the handshake.
- 7O2 frame (`DATA_WIDTH`=7, `PARITY`=2, `STOP_BITS`=2, `CLKS_PER_BIT`=3): send 0x41, which has 2 ones.
  - Required: start, then 1,0,0,0,0,0,1, then parity 1, then 1,1.
  - Required: 11 bits × 3 = 33 cycles.
- Even parity: 8E1, send 0x07, which has 3 ones. Required: parity bit = 1.
- Back-to-back: present 0x55 then 0xAA with `s_valid` held high.
  - Required: the second word is accepted during the first frame.
  - Required: the second start bit immediately follows the first stop bit with 0 idle cycles.
  - Required: `tx_active` never drops; `tx_done` pulses twice.
  - Required: a third word waits with `s_ready`=0 until the second word is loaded.
- Reset mid-frame: assert `rst` during data bit 3.
  - Required: `tx_line`=1 on the next cycle, no `tx_done`, and the pending held word is discarded.
  - Required: a fresh word after reset is sent correctly.
